// File: rtl/mtimer_irq_gen_pkg.sv
// Shared definitions for the machine-timer interrupt source: register offsets,
// control/status bit positions, FSM encoding and reset constants.
package mtimer_pkg;

    localparam logic [2:0] OFF_MTIME_LO    = 3'd0;
    localparam logic [2:0] OFF_MTIME_HI    = 3'd1;
    localparam logic [2:0] OFF_MTIMECMP_LO = 3'd2;
    localparam logic [2:0] OFF_MTIMECMP_HI = 3'd3;
    localparam logic [2:0] OFF_CTRL        = 3'd4;
    localparam logic [2:0] OFF_STATUS      = 3'd5;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_PRESC_LSB  = 8;
    localparam int STATUS_PEND_BIT = 0;
    localparam int STATUS_WRAP_BIT = 1;

    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        DONE = 2'd2
    } mt_state_t;

endpackage

// File: rtl/mtimer_irq_gen_tick_prescaler.sv
// Divides the system clock into mtime ticks: one tick every PRESC+1 enabled cycles.
module tick_prescaler #(
    parameter int PRESC_W = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               en,
    input  logic               clr,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick
);

    logic [PRESC_W-1:0] count_q;
    logic [PRESC_W-1:0] count_d;

    // A control write restarts the period, so it also suppresses a tick that cycle.
    always_comb begin
        tick    = en && !clr && (count_q == presc);
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = tick ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mtimer_irq_gen.sv
// Memory-mapped 64-bit machine timer with compare match interrupt, held until
// the processor acknowledges trap entry or software rewrites the compare value.
//
//   state | meaning
//   IDLE  | armed, waiting for mtime >= mtimecmp while enabled
//   PEND  | interrupt asserted, waiting for trap-entry acknowledge
//   DONE  | acknowledged; disarmed until a compare register write
module mtimer_irq_gen
    import mtimer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
    parameter int          PRESC_W   = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        bus_sel,
    input  logic        bus_we,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        interupt,
    input  logic        interupt_ack
);

    logic [63:0]        mtime_q, mtime_d, mtime_inc;
    logic [63:0]        cmp_q, cmp_d;
    logic               en_q, en_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [31:0]        shadow_q, shadow_d;
    logic               wrap_q, wrap_d, wrap_set;
    mt_state_t          state_q, state_d;
    logic               irq_q, irq_d;

    logic       hit, wr, rd, tick, match, cmp_wr;
    logic [2:0] off;
    logic       wr_mtime_lo, wr_mtime_hi, wr_cmp_lo, wr_cmp_hi, wr_ctrl, wr_status;
    logic       unused_addr_bits;

    assign unused_addr_bits = ^bus_addr[1:0];

    assign hit = bus_sel && (bus_addr[31:5] == BASE_ADDR[31:5]);
    assign wr  = hit && bus_we;
    assign rd  = hit && !bus_we;
    assign off = bus_addr[4:2];

    assign wr_mtime_lo = wr && (off == OFF_MTIME_LO);
    assign wr_mtime_hi = wr && (off == OFF_MTIME_HI);
    assign wr_cmp_lo   = wr && (off == OFF_MTIMECMP_LO);
    assign wr_cmp_hi   = wr && (off == OFF_MTIMECMP_HI);
    assign wr_ctrl     = wr && (off == OFF_CTRL);
    assign wr_status   = wr && (off == OFF_STATUS);
    assign cmp_wr      = wr_cmp_lo || wr_cmp_hi;

    tick_prescaler #(.PRESC_W(PRESC_W)) u_presc (
        .clock (clock),
        .reset (reset),
        .en    (en_q),
        .clr   (wr_ctrl),
        .presc (presc_q),
        .tick  (tick)
    );

    assign mtime_inc = mtime_q + {63'd0, tick};
    assign match     = en_q && (mtime_q >= cmp_q);

    // A write to one half of mtime replaces that half only; the other half
    // keeps its own increment path with no carry across the split.
    always_comb begin
        mtime_d  = mtime_inc;
        cmp_d    = cmp_q;
        en_d     = en_q;
        presc_d  = presc_q;
        shadow_d = shadow_q;
        if (wr_mtime_lo) mtime_d = {mtime_q[63:32], bus_wdata};
        if (wr_mtime_hi) mtime_d = {bus_wdata, mtime_inc[31:0]};
        if (wr_cmp_lo)   cmp_d[31:0]  = bus_wdata;
        if (wr_cmp_hi)   cmp_d[63:32] = bus_wdata;
        if (wr_ctrl) begin
            en_d    = bus_wdata[CTRL_EN_BIT];
            presc_d = bus_wdata[CTRL_PRESC_LSB +: PRESC_W];
        end
        if (rd && (off == OFF_MTIME_LO)) shadow_d = mtime_q[63:32];
    end

    assign wrap_set = tick && !wr_mtime_lo && !wr_mtime_hi && (&mtime_q);
    assign wrap_d   = (wrap_q && !(wr_status && bus_wdata[STATUS_WRAP_BIT])) || wrap_set;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mtime_q  <= '0;
            cmp_q    <= MTIMECMP_RST;
            en_q     <= 1'b0;
            presc_q  <= '0;
            shadow_q <= '0;
            wrap_q   <= 1'b0;
        end else begin
            mtime_q  <= mtime_d;
            cmp_q    <= cmp_d;
            en_q     <= en_d;
            presc_q  <= presc_d;
            shadow_q <= shadow_d;
            wrap_q   <= wrap_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            irq_q   <= irq_d;
        end
    end

    // Compare writes are the software clear/re-arm path and beat everything else.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (match) state_d = PEND;
            PEND:    if (interupt_ack) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
        if (cmp_wr) state_d = IDLE;
    end

    always_comb begin
        irq_d = (state_d == PEND);
    end

    assign interupt = irq_q;

    always_comb begin
        bus_rdata = '0;
        if (hit) begin
            case (off)
                OFF_MTIME_LO:    bus_rdata = mtime_q[31:0];
                OFF_MTIME_HI:    bus_rdata = shadow_q;
                OFF_MTIMECMP_LO: bus_rdata = cmp_q[31:0];
                OFF_MTIMECMP_HI: bus_rdata = cmp_q[63:32];
                OFF_CTRL: begin
                    bus_rdata[CTRL_EN_BIT] = en_q;
                    bus_rdata[CTRL_PRESC_LSB +: PRESC_W] = presc_q;
                end
                OFF_STATUS: begin
                    bus_rdata[STATUS_PEND_BIT] = (state_q == PEND);
                    bus_rdata[STATUS_WRAP_BIT] = wrap_q;
                end
                default:         bus_rdata = '0;
            endcase
        end
    end

endmodule

// File: doc/mtimer_irq_gen.md
# mtimer_irq_gen

Memory-mapped machine-timer block that generates the `interupt` request consumed by the processor's interrupt/CSR unit, replacing the hand-driven stimulus pulse with a real hardware source. It sits on the processor's data-memory-stage load/store path as a small register slave. It holds a 64-bit free-running `mtime`, a 64-bit `mtimecmp` and a prescaler. It raises `interupt` on compare match and holds it until the processor acknowledges trap entry.

## Interface
- `BASE_ADDR`, 32'h0000_0400, byte base address of the 8-word register window
- `PRESC_W`, 8, prescaler width in bits
- `clock`  in  1  system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `bus_sel`  in  1  access strobe: address decoded into this window
- `bus_we`  in  1  1 = write, 0 = read (valid with `bus_sel`)
- `bus_addr`  in  32  byte address; bits [4:2] select the register, bits [1:0] are ignored
- `bus_wdata`  in  32  write data, full-word writes only
- `bus_rdata`  out  32  read data, combinational from `bus_addr`; 0 when `bus_sel`=0
- `interupt`  out  1  registered interrupt request to the processor
- `interupt_ack`  in  1  one-cycle pulse from the processor on trap entry (mepc written)

## Operation
- Register map (word offset):
  - 0 MTIME_LO
  - 1 MTIME_HI
  - 2 MTIMECMP_LO
  - 3 MTIMECMP_HI
  - 4 CTRL: bit0 EN, bits[8+PRESC_W-1:8] PRESC
  - 5 STATUS: bit0 PENDING (read-only), bit1 WRAP (sticky, write-1-clear)
  - 6-7 read 0, writes ignored
- Reset values:
  - mtime = 0, mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, CTRL = 0, STATUS = 0
  - HI shadow = 0, prescale count = 0, state IDLE, `interupt` = 0
- Prescaler:
  - When EN=1, the count runs 0..PRESC.
  - A tick fires on the cycle count==PRESC, then the count returns to 0.
  - PRESC=0 gives a tick every cycle.
  - EN=0 freezes the count and mtime.
  - A write to CTRL clears the count.
- mtime increments by 1 on each tick.
  - Wrap 2^64-1 -> 0 sets STATUS.WRAP.
- Coherent reads:
  - A read of MTIME_LO copies mtime[63:32] into the HI shadow.
  - A read of MTIME_HI returns the shadow, not the live value.
- Match condition: EN && (mtime >= mtimecmp), 64-bit unsigned compare on registered values.
- FSM states:
  - IDLE: `interupt`=0. On match, go to PEND.
  - PEND: `interupt`=1, PENDING=1. On `interupt_ack`, go to DONE.
  - DONE: `interupt`=0. Stays in DONE even while match is still true. A write to MTIMECMP_LO or MTIMECMP_HI returns it to IDLE (re-arm).
- Writes to MTIMECMP_LO/HI in any state:
  - Force the next state to IDLE.
  - Deassert `interupt` on the next edge; this is the software clear path.
- `interupt_ack` in IDLE or DONE is ignored.
- Clearing EN while in PEND does not drop the request; it is held until ack or a compare write.

## Timing
- Registered output: mtime equal to mtimecmp at edge N gives `interupt`=1 after edge N+1.
- Ack at edge M gives `interupt`=0 after edge M.
- Reads have zero latency (combinational `bus_rdata`). The HI shadow updates at the edge that ends the LO read.
- Writes take effect at the edge where `bus_sel && bus_we`. A read in the same cycle returns the old value.
- Simultaneous events:
  - Tick and MTIME_LO/HI write in the same cycle: the write wins, with no increment on that half.
  - LO write plus carry into HI from a tick: the write wins on LO, and HI keeps its old value.
  - MTIMECMP write and `interupt_ack` in the same cycle: the compare write wins (go to IDLE).
  - Match and MTIMECMP write in the same cycle from IDLE: the write wins; match is re-evaluated next cycle against the new value.
- Reset asserted mid-PEND: `interupt` drops immediately (asynchronous). All registers go to their reset values.

## Structure
- `mtimer_pkg`:
  - register offset localparams
  - `mt_state_t` enum {IDLE, PEND, DONE}
  - CTRL/STATUS bit positions
  - MTIMECMP reset constant
- Sub-module `tick_prescaler`:
  - parameter PRESC_W
  - ports `clock`, `reset`, `en`, `clr`, `presc`, `tick`
- Top level holds the register file, the HI shadow, the compare logic and the FSM.

## Test plan
- Reset, CTRL=1 (PRESC=0), MTIMECMP={0,10}:
  - `interupt` rises after the edge where mtime reaches 10.
  - Ack pulse -> 0 the next cycle; stays 0 with mtime > 10.
- PRESC=3, MTIMECMP=4: mtime increments every 4th cycle; `interupt` at cycle ~17 after EN.
- In PEND, write MTIMECMP_LO=100 in the same cycle as `interupt_ack`:
  - next state IDLE, `interupt`=0
  - re-fires when mtime reaches 100
- Write MTIME={32'hFFFF_FFFF, 32'hFFFF_FFFE}, EN=1:
  - after 2 ticks mtime=0 and WRAP=1
  - writing STATUS=2 clears WRAP
- Coherent read across carry: mtime={0, FFFF_FFFF}. Read LO, tick, then read HI: HI returns 0, not 1.
- Assert `reset` while `interupt`=1: output 0 without a clock edge; all registers read their reset values.
